// File: rtl/ip_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ip_pkg
// Description : Shared IPv4/Ethernet TX constants, the latched TX header
//               struct, the inserter state enum and the header byte mux.
// Revision    : 1.0 - initial release
// ============================================================================
package ip_pkg;

    localparam logic [3:0]  IPV4_VERSION  = 4'd4;
    localparam logic [3:0]  IPV4_IHL      = 4'd5;
    localparam logic [15:0] ETH_HDR_BYTES = 16'd14;
    localparam logic [15:0] IP_HDR_BYTES  = 16'd20;
    localparam logic [15:0] ETH_MIN_FRAME = 16'd60;
    localparam int          IP_HDR_WORDS  = 10;

    typedef struct packed {
        logic [47:0] eth_dest_mac;
        logic [47:0] eth_src_mac;
        logic [15:0] eth_type;
        logic [5:0]  dscp;
        logic [1:0]  ecn;
        logic [15:0] length;
        logic [15:0] identification;
        logic [2:0]  flags;
        logic [12:0] fragment_offset;
        logic [7:0]  ttl;
        logic [7:0]  protocol;
        logic [31:0] source_ip;
        logic [31:0] dest_ip;
    } ip_tx_hdr_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_PAD     = 2'd3
    } state_t;

    // Byte idx (0..33) of the combined Ethernet + IPv4 header, big-endian.
    function automatic logic [7:0] tx_hdr_byte(input ip_tx_hdr_t h,
                                               input logic [15:0] csum,
                                               input logic [5:0] idx);
        logic [271:0] v;
        v = {h.eth_dest_mac, h.eth_src_mac, h.eth_type,
             IPV4_VERSION, IPV4_IHL, h.dscp, h.ecn, h.length,
             h.identification, h.flags, h.fragment_offset,
             h.ttl, h.protocol, csum, h.source_ip, h.dest_ip};
        return v[271 - 8*int'(idx) -: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ip_checksum_gen.sv
`default_nettype none
// ============================================================================
// Module      : ip_checksum_gen
// Description : Iterative IPv4 header checksum, one 16-bit word per clock.
//               start clears the accumulator; words[0..9] are added on the
//               following 10 clocks with end-around carry, then done pulses
//               for one cycle with the inverted sum on csum.
// Ports       : clk, reset (sync, active-high), start, words[10][16] in;
//               done, csum[16] out.
// Revision    : 1.0 - initial release
// ============================================================================
module ip_checksum_gen
    import ip_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [IP_HDR_WORDS-1:0][15:0] words,
    output logic                          done,
    output logic [15:0]                   csum
);

    logic        r_busy;
    logic [3:0]  r_idx;
    logic [15:0] r_sum;
    logic        r_done;
    logic [15:0] r_csum;

    logic [16:0] w_add;
    logic [15:0] w_fold;

    // A single fold suffices: FFFF+FFFF folds to FFFF without a new carry.
    assign w_add  = {1'b0, r_sum} + {1'b0, words[r_idx]};
    assign w_fold = w_add[15:0] + {15'd0, w_add[16]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_idx  <= 4'd0;
            r_sum  <= 16'd0;
            r_done <= 1'b0;
            r_csum <= 16'd0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_busy <= 1'b1;
                r_idx  <= 4'd0;
                r_sum  <= 16'd0;
            end else if (r_busy) begin
                r_sum <= w_fold;
                if (r_idx == 4'(IP_HDR_WORDS - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_csum <= ~w_fold;
                end else begin
                    r_idx <= r_idx + 4'd1;
                end
            end
        end
    end

    assign done = r_done;
    assign csum = r_csum;

endmodule
`default_nettype wire

// File: rtl/ip_tx_header_inserter.sv
`default_nettype none
// ============================================================================
// Module      : ip_tx_header_inserter
// Description : Accepts one IPv4 TX header and its 8-bit payload stream and
//               emits 14B Ethernet header + 20B IPv4 header (checksum
//               generated here) + payload + optional zero pad to 60 bytes.
// Ports       : clk, reset (sync, active-high)
//               hdr_valid/hdr_ready + hdr_* fields     header handshake
//               s_tdata/s_tvalid/s_tlast/s_tready       payload in
//               m_tdata/m_tvalid/m_tlast/m_tready       framed stream out
// Revision    : 1.0 - initial release
// ============================================================================
module ip_tx_header_inserter
    import ip_pkg::*;
#(
    parameter bit         PAD_MIN_FRAME = 1'b1,
    parameter logic [7:0] TTL_OVERRIDE  = 8'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hdr_valid,
    output logic        hdr_ready,
    input  logic [47:0] hdr_eth_dest_mac,
    input  logic [47:0] hdr_eth_src_mac,
    input  logic [15:0] hdr_eth_type,
    input  logic [5:0]  hdr_dscp,
    input  logic [1:0]  hdr_ecn,
    input  logic [15:0] hdr_length,
    input  logic [15:0] hdr_identification,
    input  logic [2:0]  hdr_flags,
    input  logic [12:0] hdr_fragment_offset,
    input  logic [7:0]  hdr_ttl,
    input  logic [7:0]  hdr_protocol,
    input  logic [31:0] hdr_source_ip,
    input  logic [31:0] hdr_dest_ip,
    input  logic [7:0]  s_tdata,
    input  logic        s_tvalid,
    input  logic        s_tlast,
    output logic        s_tready,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    output logic        m_tlast,
    input  logic        m_tready
);

    localparam logic [15:0] c_last_hdr_byte = ETH_HDR_BYTES + IP_HDR_BYTES - 16'd1;
    localparam logic [15:0] c_last_pad_byte = ETH_MIN_FRAME - 16'd1;

    state_t      r_state;
    state_t      w_next_state;
    ip_tx_hdr_t  r_hdr;
    ip_tx_hdr_t  w_hdr_in;
    logic [15:0] r_byte_cnt;
    logic [15:0] r_csum;

    logic        w_hdr_accept;
    logic        w_out_hs;
    logic        w_need_pad;
    logic [7:0]  w_hdr_byte;
    logic        w_csum_done;
    logic [15:0] w_csum;
    logic [IP_HDR_WORDS-1:0][15:0] w_csum_words;

    always_comb begin
        w_hdr_in.eth_dest_mac    = hdr_eth_dest_mac;
        w_hdr_in.eth_src_mac     = hdr_eth_src_mac;
        w_hdr_in.eth_type        = hdr_eth_type;
        w_hdr_in.dscp            = hdr_dscp;
        w_hdr_in.ecn             = hdr_ecn;
        w_hdr_in.length          = hdr_length;
        w_hdr_in.identification  = hdr_identification;
        w_hdr_in.flags           = hdr_flags;
        w_hdr_in.fragment_offset = hdr_fragment_offset;
        w_hdr_in.ttl             = (TTL_OVERRIDE != 8'd0) ? TTL_OVERRIDE : hdr_ttl;
        w_hdr_in.protocol        = hdr_protocol;
        w_hdr_in.source_ip       = hdr_source_ip;
        w_hdr_in.dest_ip         = hdr_dest_ip;
    end

    // Checksum words come from the latched header, so summing starts the
    // cycle after accept and finishes long before header byte 24 is due.
    always_comb begin
        w_csum_words[0] = {IPV4_VERSION, IPV4_IHL, r_hdr.dscp, r_hdr.ecn};
        w_csum_words[1] = r_hdr.length;
        w_csum_words[2] = r_hdr.identification;
        w_csum_words[3] = {r_hdr.flags, r_hdr.fragment_offset};
        w_csum_words[4] = {r_hdr.ttl, r_hdr.protocol};
        w_csum_words[5] = 16'd0;
        w_csum_words[6] = r_hdr.source_ip[31:16];
        w_csum_words[7] = r_hdr.source_ip[15:0];
        w_csum_words[8] = r_hdr.dest_ip[31:16];
        w_csum_words[9] = r_hdr.dest_ip[15:0];
    end

    ip_checksum_gen u_csum (
        .clk   (clk),
        .reset (reset),
        .start (w_hdr_accept),
        .words (w_csum_words),
        .done  (w_csum_done),
        .csum  (w_csum)
    );

    assign w_hdr_byte   = tx_hdr_byte(r_hdr, r_csum, r_byte_cnt[5:0]);
    assign w_hdr_accept = hdr_valid & hdr_ready;
    assign w_out_hs     = m_tvalid & m_tready;
    // Frame length after the current byte would be r_byte_cnt+1.
    assign w_need_pad   = PAD_MIN_FRAME && (r_byte_cnt < c_last_pad_byte);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_hdr      <= '0;
            r_byte_cnt <= 16'd0;
            r_csum     <= 16'd0;
        end else begin
            r_state <= w_next_state;
            if (w_hdr_accept) begin
                r_hdr      <= w_hdr_in;
                r_byte_cnt <= 16'd0;
            end else if (w_out_hs && (r_byte_cnt != 16'hFFFF)) begin
                r_byte_cnt <= r_byte_cnt + 16'd1;
            end
            if (w_csum_done) begin
                r_csum <= w_csum;
            end
        end
    end

    // All outputs are forced quiet while reset is held so an abort drops
    // the stream immediately.
    always_comb begin
        w_next_state = r_state;
        hdr_ready    = 1'b0;
        s_tready     = 1'b0;
        m_tdata      = 8'd0;
        m_tvalid     = 1'b0;
        m_tlast      = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_IDLE: begin
                    hdr_ready = 1'b1;
                    if (hdr_valid) begin
                        w_next_state = ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    m_tvalid = 1'b1;
                    m_tdata  = w_hdr_byte;
                    if (m_tready && (r_byte_cnt == c_last_hdr_byte)) begin
                        w_next_state = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    m_tdata  = s_tdata;
                    m_tvalid = s_tvalid;
                    s_tready = m_tready;
                    m_tlast  = s_tlast && !w_need_pad;
                    if (s_tvalid && m_tready && s_tlast) begin
                        w_next_state = w_need_pad ? ST_PAD : ST_IDLE;
                    end
                end
                ST_PAD: begin
                    m_tvalid = 1'b1;
                    m_tlast  = (r_byte_cnt == c_last_pad_byte);
                    if (m_tready && m_tlast) begin
                        w_next_state = ST_IDLE;
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ip_tx_header_inserter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ip_tx_header_inserter
// Description : Directed self-checking bench for ip_tx_header_inserter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ip_tx_header_inserter;
    import ip_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hdr_valid = 1'b0;
    logic        hdr_ready;
    ip_tx_hdr_t  th = '0;
    logic [7:0]  s_tdata = 8'd0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready = 1'b1;

    always #5 clk = ~clk;

    ip_tx_header_inserter dut (
        .clk                 (clk),
        .reset               (reset),
        .hdr_valid           (hdr_valid),
        .hdr_ready           (hdr_ready),
        .hdr_eth_dest_mac    (th.eth_dest_mac),
        .hdr_eth_src_mac     (th.eth_src_mac),
        .hdr_eth_type        (th.eth_type),
        .hdr_dscp            (th.dscp),
        .hdr_ecn             (th.ecn),
        .hdr_length          (th.length),
        .hdr_identification  (th.identification),
        .hdr_flags           (th.flags),
        .hdr_fragment_offset (th.fragment_offset),
        .hdr_ttl             (th.ttl),
        .hdr_protocol        (th.protocol),
        .hdr_source_ip       (th.source_ip),
        .hdr_dest_ip         (th.dest_ip),
        .s_tdata             (s_tdata),
        .s_tvalid            (s_tvalid),
        .s_tlast             (s_tlast),
        .s_tready            (s_tready),
        .m_tdata             (m_tdata),
        .m_tvalid            (m_tvalid),
        .m_tlast             (m_tlast),
        .m_tready            (m_tready)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    logic bp_en = 1'b0;

    // Output monitor: records every handshaked byte, sampled mid-cycle.
    int         cyc = 0;
    int         tlast_seen = 0;
    logic [7:0] rec_data[$];
    logic       rec_last[$];
    int         rec_cyc[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!reset && m_tvalid && m_tready) begin
            rec_data.push_back(m_tdata);
            rec_last.push_back(m_tlast);
            rec_cyc.push_back(cyc);
            if (m_tlast) tlast_seen <= tlast_seen + 1;
        end
    end

    // Downstream backpressure source.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    logic [7:0] pl[$];
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ref_csum(input ip_tx_hdr_t h);
        logic [31:0] s;
        s = 32'({4'h4, 4'h5, h.dscp, h.ecn}) + 32'(h.length) + 32'(h.identification)
          + 32'({h.flags, h.fragment_offset}) + 32'({h.ttl, h.protocol})
          + 32'(h.source_ip[31:16]) + 32'(h.source_ip[15:0])
          + 32'(h.dest_ip[31:16]) + 32'(h.dest_ip[15:0]);
        s = 32'(s[15:0]) + 32'(s[31:16]);
        s = 32'(s[15:0]) + 32'(s[31:16]);
        return ~s[15:0];
    endfunction

    task automatic push_be(input logic [47:0] v, input int nbytes);
        for (int i = nbytes - 1; i >= 0; i--) exp_q.push_back(v[8*i +: 8]);
    endtask

    task automatic build_exp();
        exp_q.delete();
        push_be(th.eth_dest_mac, 6);
        push_be(th.eth_src_mac, 6);
        push_be(48'(th.eth_type), 2);
        push_be(48'({8'h45, th.dscp, th.ecn}), 2);
        push_be(48'(th.length), 2);
        push_be(48'(th.identification), 2);
        push_be(48'({th.flags, th.fragment_offset}), 2);
        push_be(48'({th.ttl, th.protocol}), 2);
        push_be(48'(ref_csum(th)), 2);
        push_be(48'(th.source_ip), 4);
        push_be(48'(th.dest_ip), 4);
        foreach (pl[i]) exp_q.push_back(pl[i]);
        while (exp_q.size() < 60) exp_q.push_back(8'h00);
    endtask

    task automatic fill_payload(input int n, input int mul, input int add);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(8'(i * mul + add));
    endtask

    task automatic set_hdr(input logic [31:0] sip, input logic [31:0] dip, input logic [7:0] ttl,
                           input logic [15:0] len);
        th = '0;
        th.eth_dest_mac = 48'hFFFF_FFFF_FFFF;
        th.eth_src_mac  = 48'h0200_0000_0001;
        th.eth_type     = 16'h0800;
        th.length       = len;
        th.flags        = 3'd2;
        th.ttl          = ttl;
        th.protocol     = 8'd17;
        th.source_ip    = sip;
        th.dest_ip      = dip;
    endtask

    task automatic send_hdr();
        logic ok = 1'b0;
        hdr_valid = 1'b1;
        for (int k = 0; k < 500 && !ok; k++) begin
            @(negedge clk);
            ok = hdr_ready;
            step();
        end
        hdr_valid = 1'b0;
        if (!ok) chk("hdr_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_payload(input bit gaps);
        for (int i = 0; i < pl.size(); i++) begin
            logic ok = 1'b0;
            if (gaps && $urandom_range(0, 2) == 0) begin
                s_tvalid = 1'b0;
                step();
            end
            s_tvalid = 1'b1;
            s_tdata  = pl[i];
            s_tlast  = (i == pl.size() - 1);
            for (int k = 0; k < 500 && !ok; k++) begin
                @(negedge clk);
                ok = s_tready;
                step();
            end
            if (!ok) begin
                chk("payload_timeout", 32'd0, 32'd1);
                break;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_last(input int target);
        int k = 0;
        while (tlast_seen < target && k < 2000) begin
            step();
            k++;
        end
        if (tlast_seen < target) chk("tlast_timeout", 32'(tlast_seen), 32'(target));
        step();
    endtask

    // Compares n recorded bytes starting at base against exp_q.
    task automatic check_frame(input string tag, input int base, input int n);
        int mism = 0;
        int lpos = -1;
        chk({tag, "_len"}, 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            if (rec_data[base + i] !== exp_q[i]) mism++;
            if (rec_last[base + i] && lpos < 0) lpos = i;
        end
        chk({tag, "_bytes_mismatched"}, 32'(mism), 32'd0);
        chk({tag, "_tlast_pos"}, 32'(lpos), 32'(exp_q.size() - 1));
    endtask

    task automatic run_frame(input string tag, input bit gaps);
        int base = rec_data.size();
        int tl   = tlast_seen;
        build_exp();
        send_hdr();
        send_payload(gaps);
        wait_last(tl + 1);
        check_frame(tag, base, rec_data.size() - base);
    endtask

    initial begin
        int base;
        int tl;
        int k;

        // Reset behaviour
        repeat (3) step();
        @(negedge clk);
        chk("rst_hdr_ready", 32'(hdr_ready), 32'd0);
        chk("rst_m_tvalid",  32'(m_tvalid),  32'd0);
        chk("rst_m_tlast",   32'(m_tlast),   32'd0);
        chk("rst_m_tdata",   32'(m_tdata),   32'd0);
        chk("rst_s_tready",  32'(s_tready),  32'd0);
        step();
        reset = 1'b0;
        step();
        @(negedge clk);
        chk("post_rst_hdr_ready", 32'(hdr_ready), 32'd1);
        step();

        // Test 1: 8B payload, padded to 60 bytes.
        // Hand sum: 4500+001C+0000+4000+4011+0000+C0A8+010A+C0A8+0101 -> 488A, inverted B775.
        set_hdr(32'hC0A8_010A, 32'hC0A8_0101, 8'd64, 16'h001C);
        fill_payload(8, 1, 8'hA0);
        base = rec_data.size();
        run_frame("t1", 1'b0);
        chk("t1_checksum", 32'({rec_data[base + 24], rec_data[base + 25]}), 32'hB775);
        chk("t1_pad_byte59", 32'(rec_data[base + 59]), 32'h00);

        // Test 2: 100B payload, no pad, 134 bytes.
        fill_payload(100, 3, 1);
        base = rec_data.size();
        run_frame("t2", 1'b0);
        chk("t2_size", 32'(rec_data.size() - base), 32'd134);

        // Test 3: backpressure and source gaps, same streams.
        bp_en = 1'b1;
        fill_payload(8, 1, 8'hA0);
        run_frame("t3a", 1'b1);
        fill_payload(100, 3, 1);
        run_frame("t3b", 1'b1);
        bp_en = 1'b0;
        step();

        // Test 4: two back-to-back frames of 64 bytes each.
        fill_payload(30, 5, 7);
        build_exp();
        base = rec_data.size();
        tl = tlast_seen;
        send_hdr();
        send_payload(1'b0);
        send_hdr();
        send_payload(1'b0);
        wait_last(tl + 2);
        chk("t4_total", 32'(rec_data.size() - base), 32'd128);
        check_frame("t4_f1", base, 64);
        check_frame("t4_f2", base + 64, rec_data.size() - base - 64);
        chk("t4_gap", 32'(rec_cyc[base + 64] - rec_cyc[base + 63]), 32'd2);

        // Test 5: reset at header byte 20, then a clean carry-case frame (test 6).
        set_hdr(32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd255, 16'h001C);
        fill_payload(8, 7, 2);
        base = rec_data.size();
        tl = tlast_seen;
        hdr_valid = 1'b1;
        k = 0;
        while (rec_data.size() - base < 20 && k < 200) begin
            step();
            hdr_valid = 1'b0;
            k++;
        end
        hdr_valid = 1'b0;
        chk("t5_reached_byte20", 32'(rec_data.size() - base), 32'd20);
        reset = 1'b1;
        step();
        @(negedge clk);
        chk("t5_m_tvalid_in_reset", 32'(m_tvalid), 32'd0);
        chk("t5_hdr_ready_in_reset", 32'(hdr_ready), 32'd0);
        step();
        reset = 1'b0;
        step();
        @(negedge clk);
        chk("t5_m_tvalid_after_reset", 32'(m_tvalid), 32'd0);
        chk("t5_no_tlast", 32'(tlast_seen), 32'(tl));
        step();

        // Words 4500,001C,0000,4000,FF11,0000,FFFFx4 -> 842E, inverted 7BD1.
        base = rec_data.size();
        run_frame("t6", 1'b0);
        chk("t6_checksum", 32'({rec_data[base + 24], rec_data[base + 25]}), 32'h7BD1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
